i2c_master_ctrl: RTL

I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

---
 rtl/i2c_master_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/i2c_master_ctrl.sv
// I2C master bit-level controller.
// Drives SDA/SCL open-drain enables from divider phases supplied by an
// external clock divider. Sequences START, address/rw, write or read
// bytes with ACK handling, and STOP. Repeated START is not generated; a
// change of address or direction ends the transfer with STOP.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | bus free, waiting for ena at a drive point
// START | SDA pulled low with SCL released (START condition)
// ADDR  | shifting out {addr,rw}, MSB first
// SACK1 | SDA released, sampling slave ACK for the address byte
// WR    | shifting out the write byte, MSB first
// RD    | SDA released, shifting in the read byte at sample points
// SACK2 | SDA released, sampling slave ACK for a written byte
// MACK  | master ACK (continue) or NACK (last byte) for a read byte
// STOP  | SDA held low until SCL is released, then SDA released

module i2c_master_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_clk,
    input  logic       data_clk,
    input  logic       data_clk_prev,
    input  logic       ena,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] data_wr,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic       busy,
    output logic [7:0] data_rd,
    output logic       ack_error
);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, SACK1, WR, RD, SACK2, MACK, STOP
    } state_t;

    state_t     state;
    logic       scl_ena;
    logic [2:0] bit_cnt;
    logic [7:0] addr_rw;
    logic [7:0] data_tx;
    logic [7:0] data_rx;
    logic       dp;
    logic       sp;
    logic       cmd_same;

    // Drive point sits mid SCL-low, sample point mid SCL-high.
    assign dp = data_clk & ~data_clk_prev;
    assign sp = ~data_clk & data_clk_prev;

    // SCL is only pulled low while the transfer owns the clock.
    assign scl_oe = scl_ena & ~scl_clk;

    // Continuing a transfer requires the same target and direction.
    assign cmd_same = ena && ({addr, rw} == addr_rw);

    // Main sequencer: transitions and SDA drive at DP, line sampling at SP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            sda_oe    <= 1'b0;
            scl_ena   <= 1'b0;
            ack_error <= 1'b0;
            data_rd   <= 8'h00;
            bit_cnt   <= 3'd7;
            addr_rw   <= 8'h00;
            data_tx   <= 8'h00;
            data_rx   <= 8'h00;
        end else begin
            if (dp) begin
                case (state)
                    IDLE: begin
                        if (ena) begin
                            addr_rw   <= {addr, rw};
                            data_tx   <= data_wr;
                            busy      <= 1'b1;
                            ack_error <= 1'b0;
                            sda_oe    <= 1'b1;
                            bit_cnt   <= 3'd7;
                            state     <= START;
                        end
                    end
                    START: begin
                        sda_oe <= ~addr_rw[bit_cnt];
                        state  <= ADDR;
                    end
                    ADDR: begin
                        if (bit_cnt == 3'd0) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 3'd7;
                            state   <= SACK1;
                        end else begin
                            bit_cnt <= bit_cnt - 3'd1;
                            sda_oe  <= ~addr_rw[bit_cnt - 3'd1];
                        end
                    end
                    SACK1: begin
                        if (!addr_rw[0]) begin
                            sda_oe <= ~data_tx[7];
                            state  <= WR;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= RD;
                        end
                    end
                    WR: begin
                        if (bit_cnt == 3'd0) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 3'd7;
                            state   <= SACK2;
                        end else begin
                            bit_cnt <= bit_cnt - 3'd1;
                            sda_oe  <= ~data_tx[bit_cnt - 3'd1];
                        end
                    end
                    SACK2: begin
                        if (cmd_same) begin
                            data_tx <= data_wr;
                            sda_oe  <= ~data_wr[7];
                            state   <= WR;
                        end else begin
                            sda_oe <= 1'b1;
                            state  <= STOP;
                        end
                    end
                    RD: begin
                        if (bit_cnt == 3'd0) begin
                            data_rd <= data_rx;
                            bit_cnt <= 3'd7;
                            // sda_oe doubles as the ACK/NACK decision in MACK
                            sda_oe  <= cmd_same;
                            state   <= MACK;
                        end else begin
                            bit_cnt <= bit_cnt - 3'd1;
                        end
                    end
                    MACK: begin
                        if (sda_oe) begin
                            sda_oe <= 1'b0;
                            state  <= RD;
                        end else begin
                            sda_oe <= 1'b1;
                            state  <= STOP;
                        end
                    end
                    STOP: begin
                        if (!scl_ena) begin
                            sda_oe <= 1'b0;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            if (sp) begin
                case (state)
                    START:        scl_ena <= 1'b1;
                    STOP:         scl_ena <= 1'b0;
                    SACK1, SACK2: if (sda_in) ack_error <= 1'b1;
                    RD:           data_rx <= {data_rx[6:0], sda_in};
                    default: ;
                endcase
            end
        end
    end

endmodule
